// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a UART transmitter: round-robin on ties, packets never interleaved.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned TO_CYCLES = 1023
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_gnt, last_gnt_nxt;
    logic   own_valid;
    logic   own_last;
    logic   xfer_last;
    logic   to_hit;

    if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_to_range
        $error("uart_tx_arbiter: TO_CYCLES must be within 1..65535");
    end

    // The granted requester is wired straight through; everyone else sees ready low.
    always_comb begin
        grant      = 2'b00;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        own_valid  = 1'b0;
        own_last   = 1'b0;
        case (state)
            GNT0: begin
                grant      = 2'b01;
                tx_valid   = req0_valid;
                tx_data    = req0_data;
                req0_ready = tx_ready;
                own_valid  = req0_valid;
                own_last   = req0_last;
            end
            GNT1: begin
                grant      = 2'b10;
                tx_valid   = req1_valid;
                tx_data    = req1_data;
                req1_ready = tx_ready;
                own_valid  = req1_valid;
                own_last   = req1_last;
            end
            default: ;
        endcase
    end

    assign xfer_last = tx_valid && tx_ready && own_last;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        irq_q;

    assign to_hit = (state != IDLE) && (stall_cnt == 16'(TO_CYCLES));

    // Counter is held at zero in IDLE, so every new grant starts from a clean count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stall_cnt <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= to_hit && !xfer_last;
            if (state == IDLE || own_valid) begin
                stall_cnt <= 16'd0;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign timeout_irq = irq_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_irq = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt = last_gnt ? GNT0 : GNT1;
                end else if (req0_valid) begin
                    state_nxt = GNT0;
                end else if (req1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (xfer_last || to_hit) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (xfer_last || to_hit) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

endmodule
